// File: rtl/mipi_csi2_pkg.sv
// Shared definitions for the CSI-2 capture path: FSM state encoding,
// default counter widths and the frame/line packet IDs used by the deserializer.
package mipi_csi2_pkg;

  localparam int DEF_CNT_W = 16;
  localparam int DEF_TO_W  = 24;

  localparam logic [5:0] DT_FRAME_START = 6'h00;
  localparam logic [5:0] DT_FRAME_END   = 6'h01;
  localparam logic [5:0] DT_LINE_START  = 6'h02;
  localparam logic [5:0] DT_LINE_END    = 6'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mipi_csi2_frame_checker.sv
// Edge detection on fvi/lvi plus line and per-line dvi counters, with
// compare strobes against the expected geometry at line and frame end.
module mipi_csi2_frame_checker
  import mipi_csi2_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic             i_clear,
  input  logic             i_active,
  input  logic             i_dvi,
  input  logic             i_lvi,
  input  logic             i_fvi,
  input  logic [CNT_W-1:0] i_exp_lines,
  input  logic [CNT_W-1:0] i_exp_pixels,
  output logic             o_fvi_rise,
  output logic             o_edge,
  output logic             o_line_end,
  output logic             o_frame_end,
  output logic             o_pix_mismatch,
  output logic             o_line_mismatch
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             r_fvi_d;
  logic             r_lvi_d;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] r_pix_cnt;

  logic             w_fvi_fall;
  logic             w_lvi_rise;
  logic             w_lvi_fall;
  logic [CNT_W-1:0] w_line_cnt_now;

  assign o_fvi_rise = i_fvi & ~r_fvi_d;
  assign w_fvi_fall = ~i_fvi & r_fvi_d;
  assign w_lvi_rise = i_lvi & ~r_lvi_d;
  assign w_lvi_fall = ~i_lvi & r_lvi_d;
  assign o_edge     = o_fvi_rise | w_fvi_fall | w_lvi_rise | w_lvi_fall;

  // A line ending in the same cycle as the frame must still be counted.
  assign w_line_cnt_now = (w_lvi_fall && r_line_cnt != CNT_MAX) ? r_line_cnt + CNT_ONE : r_line_cnt;

  assign o_line_end      = i_active & w_lvi_fall;
  assign o_frame_end     = i_active & w_fvi_fall;
  assign o_pix_mismatch  = w_lvi_fall & (r_pix_cnt != i_exp_pixels);
  assign o_line_mismatch = w_fvi_fall & (w_line_cnt_now != i_exp_lines);

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_fvi_d    <= 1'b0;
      r_lvi_d    <= 1'b0;
      r_line_cnt <= '0;
      r_pix_cnt  <= '0;
    end else begin
      r_fvi_d <= i_fvi;
      r_lvi_d <= i_lvi;
      if (i_clear) r_line_cnt <= '0;
      else         r_line_cnt <= w_line_cnt_now;
      if (w_lvi_fall)                      r_pix_cnt <= '0;
      else if (w_lvi_rise)                 r_pix_cnt <= {{(CNT_W-1){1'b0}}, i_dvi};
      else if (i_dvi && r_pix_cnt != CNT_MAX) r_pix_cnt <= r_pix_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/mipi_csi2_capture_ctrl.sv
// Capture sequencer between the CSI-2 deserializer and the image pipeline:
// frame-aligned start, whole-frame gating, geometry checks, abort and timeout.
module mipi_csi2_capture_ctrl
  import mipi_csi2_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int TO_W       = DEF_TO_W
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            num_frames,
  input  logic [CNT_W-1:0]      exp_lines,
  input  logic [CNT_W-1:0]      exp_pixels,
  input  logic [TO_W-1:0]       timeout_cycles,
  input  logic [DATA_WIDTH-1:0] dati,
  input  logic                  dvi,
  input  logic                  lvi,
  input  logic                  fvi,
  output logic                  des_enable,
  output logic [DATA_WIDTH-1:0] dato,
  output logic                  dvo,
  output logic                  lvo,
  output logic                  fvo,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            frame_cnt,
  output logic                  err_lines,
  output logic                  err_pixels,
  output logic                  err_timeout
);

  localparam logic [TO_W-1:0] TO_ONE = TO_W'(1);

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_des_enable;
  logic [7:0]            r_frame_cnt;
  logic                  r_err_lines;
  logic                  r_err_pixels;
  logic                  r_err_timeout;
  logic [TO_W-1:0]       r_to_cnt;
  logic [DATA_WIDTH-1:0] r_dato;
  logic                  r_dvo;
  logic                  r_lvo;
  logic                  r_fvo;

  logic       w_fvi_rise;
  logic       w_edge;
  logic       w_line_end;
  logic       w_frame_end;
  logic       w_pix_mismatch;
  logic       w_line_mismatch;
  logic       w_start_ok;
  logic       w_accept_frame;
  logic       w_clear;
  logic       w_active;
  logic       w_to_run;
  logic       w_activity;
  logic       w_to_hit;
  logic       w_gate;
  logic [7:0] w_next_cnt;
  logic       w_last_frame;

  assign w_start_ok     = (r_state == ST_IDLE) && start;
  assign w_accept_frame = (r_state == ST_ARMED) && w_fvi_rise && !abort;
  assign w_clear        = w_start_ok | w_accept_frame;
  assign w_active       = (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
  assign w_to_run       = (r_state == ST_SYNC) || (r_state == ST_ARMED) || w_active;
  assign w_activity     = w_edge | dvi;
  assign w_to_hit       = w_to_run && !w_activity && (timeout_cycles != '0) &&
                          (r_to_cnt >= timeout_cycles - TO_ONE);
  assign w_gate         = w_accept_frame | w_active;
  assign w_next_cnt     = sat_inc8(r_frame_cnt);
  assign w_last_frame   = (num_frames != 8'd0) && (w_next_cnt == num_frames);

  mipi_csi2_frame_checker #(.CNT_W(CNT_W)) u_checker (
    .clk             (clk),
    .resetb          (resetb),
    .i_clear         (w_clear),
    .i_active        (w_active),
    .i_dvi           (dvi),
    .i_lvi           (lvi),
    .i_fvi           (fvi),
    .i_exp_lines     (exp_lines),
    .i_exp_pixels    (exp_pixels),
    .o_fvi_rise      (w_fvi_rise),
    .o_edge          (w_edge),
    .o_line_end      (w_line_end),
    .o_frame_end     (w_frame_end),
    .o_pix_mismatch  (w_pix_mismatch),
    .o_line_mismatch (w_line_mismatch)
  );

  // Frame end outranks both timeout and abort so a frame in flight always completes.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_des_enable  <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_err_lines   <= 1'b0;
      r_err_pixels  <= 1'b0;
      r_err_timeout <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_done   <= 1'b0;
      r_to_cnt <= (w_to_run && !w_activity) ? r_to_cnt + TO_ONE : '0;
      if (w_line_end && w_pix_mismatch) r_err_pixels <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state       <= ST_SYNC;
            r_busy        <= 1'b1;
            r_des_enable  <= 1'b1;
            r_frame_cnt   <= 8'd0;
            r_err_lines   <= 1'b0;
            r_err_pixels  <= 1'b0;
            r_err_timeout <= 1'b0;
          end
        end
        ST_SYNC, ST_ARMED: begin
          if (abort || w_to_hit) begin
            if (w_to_hit) r_err_timeout <= 1'b1;
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_des_enable <= 1'b0;
          end else if (r_state == ST_SYNC && !fvi) begin
            r_state <= ST_ARMED;
          end else if (w_accept_frame) begin
            r_state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE, ST_DRAIN: begin
          if (w_frame_end) begin
            r_frame_cnt <= w_next_cnt;
            if (w_line_mismatch) r_err_lines <= 1'b1;
            if (r_state == ST_DRAIN || abort || w_last_frame) begin
              r_state      <= ST_DONE;
              r_done       <= 1'b1;
              r_des_enable <= 1'b0;
            end else begin
              r_state <= ST_ARMED;
            end
          end else if (w_to_hit) begin
            r_err_timeout <= 1'b1;
            r_state       <= ST_DONE;
            r_done        <= 1'b1;
            r_des_enable  <= 1'b0;
          end else if (abort) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_dato <= '0;
      r_dvo  <= 1'b0;
      r_lvo  <= 1'b0;
      r_fvo  <= 1'b0;
    end else begin
      r_dato <= w_gate ? dati : '0;
      r_dvo  <= w_gate & dvi;
      r_lvo  <= w_gate & lvi;
      r_fvo  <= w_gate & fvi;
    end
  end

  assign des_enable  = r_des_enable;
  assign dato        = r_dato;
  assign dvo         = r_dvo;
  assign lvo         = r_lvo;
  assign fvo         = r_fvo;
  assign busy        = r_busy;
  assign done        = r_done;
  assign frame_cnt   = r_frame_cnt;
  assign err_lines   = r_err_lines;
  assign err_pixels  = r_err_pixels;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_mipi_csi2_capture_ctrl.sv
// Directed bench for the CSI-2 capture sequencer: frame counting, mid-frame
// start alignment, geometry errors, abort drain, bus timeout and async reset.
module tb_mipi_csi2_capture_ctrl;

  logic        clk = 1'b0;
  logic        resetb;
  logic        start;
  logic        abort;
  logic [7:0]  num_frames;
  logic [15:0] exp_lines;
  logic [15:0] exp_pixels;
  logic [23:0] timeout_cycles;
  logic [7:0]  dati;
  logic        dvi;
  logic        lvi;
  logic        fvi;
  logic        des_enable;
  logic [7:0]  dato;
  logic        dvo;
  logic        lvo;
  logic        fvo;
  logic        busy;
  logic        done;
  logic [7:0]  frame_cnt;
  logic        err_lines;
  logic        err_pixels;
  logic        err_timeout;

  int passCount  = 0;
  int checkCount = 0;
  int fvoPulses  = 0;
  int donePulses = 0;
  logic fvoPrev  = 1'b0;

  always #5 clk = ~clk;

  mipi_csi2_capture_ctrl dut (
    .clk            (clk),
    .resetb         (resetb),
    .start          (start),
    .abort          (abort),
    .num_frames     (num_frames),
    .exp_lines      (exp_lines),
    .exp_pixels     (exp_pixels),
    .timeout_cycles (timeout_cycles),
    .dati           (dati),
    .dvi            (dvi),
    .lvi            (lvi),
    .fvi            (fvi),
    .des_enable     (des_enable),
    .dato           (dato),
    .dvo            (dvo),
    .lvo            (lvo),
    .fvo            (fvo),
    .busy           (busy),
    .done           (done),
    .frame_cnt      (frame_cnt),
    .err_lines      (err_lines),
    .err_pixels     (err_pixels),
    .err_timeout    (err_timeout)
  );

  // Counts frames passed downstream and completion pulses as seen by the pipeline.
  always @(negedge clk) begin
    if (fvo && !fvoPrev) fvoPulses++;
    if (done) donePulses++;
    fvoPrev = fvo;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic d, input logic l, input logic f, input logic [7:0] data);
    dvi  = d;
    lvi  = l;
    fvi  = f;
    dati = data;
    @(negedge clk);
  endtask

  task automatic sendLine(input int pixels);
    for (int p = 0; p < pixels; p++) applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'hA0 + p));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic sendFrame(input int lines, input int pixels, input int shortLine, input bit chk);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ((l == shortLine) ? pixels - 1 : pixels); p++) begin
        applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'hA0 + p));
        if (chk && l == 0 && p == 0) begin
          checkOutput("dato_latency", dato, 8'hA0);
          checkOutput("dvo_latency", dvo, 1);
        end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    end
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic startCapture();
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int fvoBase;
    int doneBase;
    int n;
    bit seen;

    resetb = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    num_frames = 8'd2;
    exp_lines = 16'd4;
    exp_pixels = 16'd8;
    timeout_cycles = 24'd0;
    dati = 8'h00;
    dvi = 1'b0;
    lvi = 1'b0;
    fvi = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {des_enable, busy, done, dvo, lvo, fvo, frame_cnt,
                                  err_lines, err_pixels, err_timeout, dato}, 32'h0);
    resetb = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

    $display("[TB] two of three clean frames captured");
    fvoBase = fvoPulses;
    doneBase = donePulses;
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b0;
    checkOutput("t1_busy_after_start", busy, 1);
    checkOutput("t1_des_enable_after_start", des_enable, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    sendFrame(4, 8, -1, 1'b1);
    checkOutput("t1_frame_cnt_mid", frame_cnt, 1);
    sendFrame(4, 8, -1, 1'b0);
    sendFrame(4, 8, -1, 1'b0);
    checkOutput("t1_fvo_pulses", fvoPulses - fvoBase, 2);
    checkOutput("t1_frame_cnt", frame_cnt, 2);
    checkOutput("t1_done_pulses", donePulses - doneBase, 1);
    checkOutput("t1_errors", {err_lines, err_pixels, err_timeout}, 0);
    checkOutput("t1_des_enable_off", des_enable, 0);
    checkOutput("t1_busy_off", busy, 0);

    $display("[TB] start mid-frame suppresses that frame");
    num_frames = 8'd1;
    fvoBase = fvoPulses;
    doneBase = donePulses;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    start = 1'b0;
    sendLine(8);
    sendLine(8);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("t2_partial_fvo", fvoPulses - fvoBase, 0);
    checkOutput("t2_partial_frame_cnt", frame_cnt, 0);
    sendFrame(4, 8, -1, 1'b0);
    checkOutput("t2_fvo_pulses", fvoPulses - fvoBase, 1);
    checkOutput("t2_frame_cnt", frame_cnt, 1);
    checkOutput("t2_errors", {err_lines, err_pixels, err_timeout}, 0);
    checkOutput("t2_done_pulses", donePulses - doneBase, 1);

    $display("[TB] short line and missing line flagged");
    num_frames = 8'd2;
    doneBase = donePulses;
    startCapture();
    sendFrame(3, 8, 1, 1'b0);
    checkOutput("t3_err_pixels", err_pixels, 1);
    checkOutput("t3_err_lines", err_lines, 1);
    checkOutput("t3_still_busy", busy, 1);
    sendFrame(4, 8, -1, 1'b0);
    checkOutput("t3_frame_cnt", frame_cnt, 2);
    checkOutput("t3_errors_sticky", {err_lines, err_pixels}, 2'b11);
    checkOutput("t3_done_pulses", donePulses - doneBase, 1);

    $display("[TB] continuous mode aborted mid-frame");
    num_frames = 8'd0;
    fvoBase = fvoPulses;
    doneBase = donePulses;
    startCapture();
    checkOutput("t4_errors_cleared", {err_lines, err_pixels, err_timeout}, 0);
    sendFrame(4, 8, -1, 1'b0);
    checkOutput("t4_frame_cnt_first", frame_cnt, 1);
    checkOutput("t4_busy_continuous", busy, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    sendLine(8);
    sendLine(8);
    abort = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    abort = 1'b0;
    sendLine(8);
    sendLine(8);
    checkOutput("t4_draining_busy", busy, 1);
    checkOutput("t4_draining_fvo", fvo, 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("t4_frame_cnt", frame_cnt, 2);
    checkOutput("t4_fvo_pulses", fvoPulses - fvoBase, 2);
    checkOutput("t4_done_pulses", donePulses - doneBase, 1);
    checkOutput("t4_busy_off", busy, 0);

    $display("[TB] idle bus timeout");
    timeout_cycles = 24'd100;
    start = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    start = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
      if (done) seen = 1'b1;
    end
    checkOutput("t5_done_seen", seen, 1);
    checkOutput("t5_latency_window", (n >= 99 && n <= 102), 1);
    checkOutput("t5_err_timeout", err_timeout, 1);
    checkOutput("t5_des_enable_in_done", des_enable, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("t5_busy_off", busy, 0);
    timeout_cycles = 24'd0;

    $display("[TB] asynchronous reset mid-capture");
    num_frames = 8'd0;
    startCapture();
    sendFrame(4, 8, -1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    repeat (3) applyStimulus(1'b1, 1'b1, 1'b1, 8'h5A);
    checkOutput("t6_capturing_lvo", lvo, 1);
    checkOutput("t6_capturing_frame_cnt", frame_cnt, 1);
    #2;
    resetb = 1'b0;
    dvi = 1'b0;
    lvi = 1'b0;
    fvi = 1'b0;
    #1;
    checkOutput("t6_reset_outputs", {des_enable, busy, done, dvo, lvo, fvo, frame_cnt,
                                     err_lines, err_pixels, err_timeout, dato}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetb = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
    num_frames = 8'd1;
    fvoBase = fvoPulses;
    doneBase = donePulses;
    startCapture();
    sendFrame(4, 8, -1, 1'b0);
    checkOutput("t6_restart_frame_cnt", frame_cnt, 1);
    checkOutput("t6_restart_fvo", fvoPulses - fvoBase, 1);
    checkOutput("t6_restart_done", donePulses - doneBase, 1);
    checkOutput("t6_restart_idle", {busy, des_enable}, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mipi_csi2_capture_ctrl.md
# mipi_csi2_capture_ctrl

Sequences capture from the CSI-2 deserializer. It enables the deserializer on a software start and aligns capture to a frame boundary. It passes a programmed number of whole frames downstream, checks line and pixel counts, and stops cleanly on completion, abort or bus timeout. It sits between the deserializer outputs (`dato`/`dvo`/`lvo`/`fvo`) and the image pipeline, in the `img_clk` domain.

## Interface
- `DATA_WIDTH`, 8: pixel width passed through.
- `CNT_W`, 16: width of line/pixel counters and expected values.
- `TO_W`, 24: timeout counter width.

Ports:
- `clk`  in  1  deserializer `img_clk`.
- `resetb`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request to begin capture.
- `abort`  in  1  one-cycle request to stop.
- `num_frames`  in  8  frames to capture; 0 = continuous until abort.
- `exp_lines`  in  CNT_W  expected lines per frame.
- `exp_pixels`  in  CNT_W  expected `dvi` cycles per line.
- `timeout_cycles`  in  TO_W  idle-bus limit; 0 disables.
- `dati`  in  DATA_WIDTH  from deserializer.
- `dvi`, `lvi`, `fvi`  in  1 each  from deserializer.
- `des_enable`  out  1  drives deserializer `enable`.
- `dato`  out  DATA_WIDTH  gated pixel.
- `dvo`, `lvo`, `fvo`  out  1 each  gated strobes.
- `busy`  out  1  high from start acceptance until return to IDLE.
- `done`  out  1  one-cycle pulse on every return to IDLE after a start.
- `frame_cnt`  out  8  frames completed this run.
- `err_lines`, `err_pixels`, `err_timeout`  out  1 each  sticky, cleared on accepted start.

## Operation
- All outputs reset to 0; state resets to IDLE.
- Edges of `fvi`/`lvi` come from registered previous values (reset 0).
- IDLE: `des_enable`=0. On `start` → SYNC, clear `frame_cnt`, errors and counters, `busy`=1.
- SYNC: `des_enable`=1. Wait for `fvi`=0 so capture never starts mid-frame → ARMED.
- ARMED: on `fvi` rise → CAPTURE, clear line counter.
- CAPTURE: `lvi` fall increments the line counter (saturating). At each `lvi` fall, compare `dvi` cycles in that line against `exp_pixels`; mismatch sets `err_pixels`. On `fvi` fall:
  - compare the line count with `exp_lines`; mismatch sets `err_lines`;
  - increment `frame_cnt` (saturating 255);
  - if `num_frames`≠0 and new count == `num_frames`, go to DONE; else go to ARMED.
- Abort handling:
  - `abort` in SYNC/ARMED → DONE.
  - `abort` in CAPTURE → DRAIN.
- DRAIN: behaves like CAPTURE. On `fvi` fall, do the frame-end checks and count, then go to DONE.
- DONE: one cycle. `done`=1, `des_enable`=0, `busy`=0 next cycle, then → IDLE.
- Timeout: the counter runs in SYNC/ARMED/CAPTURE/DRAIN. It clears on any `fvi`/`lvi` edge or `dvi`=1. When it reaches `timeout_cycles`(≠0): set `err_timeout` and go to DONE.
- Gating: `dato`/`dvo`/`lvo`/`fvo` are the inputs delayed one register. They are forced to 0 except from the `fvi`-rise cycle accepted in ARMED through the `fvi`-fall cycle that ends the frame. Captured frames pass whole; partial frames never pass.
- Simultaneous events:
  - `start` while `busy`: ignored.
  - `abort` with `start` in IDLE: start accepted (abort has no effect in IDLE).
  - frame end with timeout in the same cycle: frame end wins and the timeout counter clears.
  - frame end with `abort` in CAPTURE: frame completes normally; if more frames remain, go to DONE (abort honored).

## Timing
- Gated outputs have 1-cycle latency from inputs.
- `des_enable` rises the cycle after `start` is sampled and falls in the DONE cycle.
- Error flags and `frame_cnt` update the cycle after the sampled falling edge.
- Config inputs are sampled continuously. They must be static while `busy`.

## Structure
- Package `mipi_csi2_pkg` holds:
  - state encoding (IDLE, SYNC, ARMED, CAPTURE, DRAIN, DONE);
  - default `CNT_W`/`TO_W`;
  - the shared frame/line ID constants already used by the deserializer.
- One natural sub-module, `mipi_csi2_frame_checker`: edge detection plus line/pixel counters and compare. It outputs `line_end`, `frame_end` and mismatch strobes.

## Test plan
- `num_frames`=2, `exp_lines`=4, `exp_pixels`=8, 3 clean frames → `fvo` pulses exactly twice, `frame_cnt`=2, `done` once, no errors, `des_enable` low after.
- `start` while `fvi`=1 mid-frame → that frame fully suppressed (`fvo`=0), next frame passed.
- Line with 7 `dvi` cycles, frame with 3 lines → `err_pixels`=1, `err_lines`=1, capture continues.
- `num_frames`=0, `abort` mid-frame → frame completes on `fvo`, then `done`, `frame_cnt` includes it.
- `timeout_cycles`=100, bus idle after start → `err_timeout`=1 and `done` at cycle ~101, `busy`=0.
- Assert `resetb` low mid-CAPTURE → all outputs 0 immediately, state IDLE, `start` afterwards works.
